// File: rtl/inst_loader_pkg.sv
// Shared definitions for the instruction loader: FSM encoding and word geometry.
package inst_loader_pkg;

    localparam int BYTES_PER_WORD = 4;
    localparam int WORD_W         = 32;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RECV  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/inst_loader_byte_packer.sv
// Byte-to-word packer: shifts bytes in MSB-first and flags the byte that completes a word.
module inst_loader_byte_packer
    import inst_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              shift_en,
    input  logic [7:0]        in_data,
    output logic [WORD_W-1:0] word,
    output logic [1:0]        byte_cnt,
    output logic              word_full
);

    logic [WORD_W-1:0] word_reg;
    logic [1:0]        cnt_reg;

    // word_full marks the cycle in which the last byte of a word is being shifted in
    assign word_full = shift_en && (cnt_reg == 2'(BYTES_PER_WORD - 1));
    assign word      = word_reg;
    assign byte_cnt  = cnt_reg;

    // Shift register and modulo-4 byte counter; clr discards any partial word
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_reg <= '0;
            cnt_reg  <= '0;
        end else if (clr) begin
            word_reg <= '0;
            cnt_reg  <= '0;
        end else if (shift_en) begin
            word_reg <= {word_reg[WORD_W-9:0], in_data};
            cnt_reg  <= cnt_reg + 2'd1;
        end
    end

endmodule

// File: rtl/inst_loader.sv
// Instruction loader: receives a byte stream, writes 32-bit words into instruction
// memory and holds the CPU in reset until a complete program has been loaded.
module inst_loader
    import inst_loader_pkg::*;
#(
    parameter int ADDR_W    = 10,
    parameter int NUM_WORDS = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W:0]   len,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [ADDR_W:0] MAX_LEN = (ADDR_W+1)'(NUM_WORDS);

    state_t              state;
    logic [ADDR_W-1:0]   idx_reg;
    logic [ADDR_W-1:0]   last_reg;
    logic                cpu_hold_reg;
    logic                err_reg;
    logic [ADDR_W-1:0]   mem_addr_reg;
    logic [WORD_W-1:0]   mem_wdata_reg;

    logic                len_ok;
    logic                accept;
    logic                xfer;
    logic [WORD_W-1:0]   pk_word;
    logic [1:0]          pk_cnt;
    logic                pk_full;

    assign len_ok = (len != '0) && (len <= MAX_LEN);
    assign accept = (state == S_IDLE) && start && len_ok;
    assign xfer   = (state == S_RECV) && in_valid;

    // Handshake and strobes decode purely from the registered state
    assign in_ready  = (state == S_RECV);
    assign mem_we    = (state == S_WRITE);
    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE);
    assign err       = err_reg;
    assign cpu_hold  = cpu_hold_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = mem_wdata_reg;

    inst_loader_byte_packer u_byte_packer (
        .clk       (clk),
        .rst       (rst),
        .clr       (accept),
        .shift_en  (xfer),
        .in_data   (in_data),
        .word      (pk_word),
        .byte_cnt  (pk_cnt),
        .word_full (pk_full)
    );

    // Load sequencer: accepts/rejects start, steps through words, releases the CPU when done
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_IDLE;
            idx_reg       <= '0;
            last_reg      <= '0;
            cpu_hold_reg  <= 1'b1;
            err_reg       <= 1'b0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
        end else begin
            err_reg <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (len_ok) begin
                            state        <= S_RECV;
                            idx_reg      <= '0;
                            // len is at most NUM_WORDS, so len-1 always fits the address width
                            last_reg     <= ADDR_W'(len - (ADDR_W+1)'(1));
                            cpu_hold_reg <= 1'b1;
                        end else begin
                            err_reg <= 1'b1;
                        end
                    end
                end
                S_RECV: begin
                    if (pk_full) begin
                        state         <= S_WRITE;
                        mem_addr_reg  <= idx_reg;
                        mem_wdata_reg <= {pk_word[WORD_W-9:0], in_data};
                    end
                end
                S_WRITE: begin
                    if (idx_reg == last_reg) begin
                        state <= S_DONE;
                    end else begin
                        idx_reg <= idx_reg + ADDR_W'(1);
                        state   <= S_RECV;
                    end
                end
                S_DONE: begin
                    cpu_hold_reg <= 1'b0;
                    state        <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Byte count is only observed through word_full; keep it visible to tools as used
    logic unused_ok;
    assign unused_ok = ^pk_cnt;

endmodule

// File: tb/tb_inst_loader.sv
// Self-checking bench for inst_loader: directed scenarios plus randomized loads
// checked against an expected-word model built from the byte stream.
module tb_inst_loader;

    localparam int ADDR_W    = 4;
    localparam int NUM_WORDS = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [ADDR_W:0]   len;
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              cpu_hold;
    logic              busy;
    logic              done;
    logic              err;

    int n_checks = 0;
    int n_errors = 0;

    inst_loader #(.ADDR_W(ADDR_W), .NUM_WORDS(NUM_WORDS)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .len       (len),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_hold  (cpu_hold),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    // Edge counter and output monitor (sampled on the falling edge)
    int          cyc = 0;
    int          done_cnt = 0;
    int          err_cnt = 0;
    int          done_cyc = 0;
    int          start_cyc = 0;
    int          wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    logic [7:0]  tx_q[$];

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (mem_we) begin
            wr_addr_q.push_back(int'(mem_addr));
            wr_data_q.push_back(mem_wdata);
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (err) err_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int l);
        start = 1'b1;
        len   = (ADDR_W+1)'(l);
        tick();
        start_cyc = cyc;
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        bit x;
        int guard;
        repeat (gap) begin
            in_valid = 1'b0;
            tick();
        end
        in_valid = 1'b1;
        in_data  = b;
        guard = 0;
        do begin
            x = in_ready;
            tick();
            guard++;
        end while (!x && guard < 200);
        if (!x) check("byte_accept_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
    endtask

    // gapmode: 0 back-to-back, 1 one idle cycle before every byte, 2 random gaps.
    // inject_at >= 0 pulses a start (len 4) after that many bytes.
    task automatic run_load(input int l, input int gapmode, input bit chk_lat, input int inject_at);
        int          d0;
        int          e0;
        int          gap;
        int          g;
        logic [31:0] exp_w;
        if (tx_q.size() == 0)
            for (int i = 0; i < 4 * l; i++) tx_q.push_back(8'($urandom));
        wr_addr_q.delete();
        wr_data_q.delete();
        d0 = done_cnt;
        e0 = err_cnt;
        do_start(l);
        check("busy_after_start", 32'(busy), 32'd1);
        check("hold_during_load", 32'(cpu_hold), 32'd1);
        for (int i = 0; i < 4 * l; i++) begin
            if (i == inject_at) do_start(4);
            gap = (gapmode == 0) ? 0 : (gapmode == 1) ? 1 : int'($urandom_range(0, 2));
            send_byte(tx_q[i], gap);
        end
        g = 0;
        while (done_cnt == d0 && g < 30) begin
            tick();
            g++;
        end
        tick();
        check("done_pulses", 32'(done_cnt - d0), 32'd1);
        check("err_none", 32'(err_cnt - e0), 32'd0);
        check("hold_released", 32'(cpu_hold), 32'd0);
        check("idle_after_done", 32'(busy), 32'd0);
        if (chk_lat) check("done_latency", 32'(done_cyc - start_cyc), 32'(5 * l));
        check("write_count", 32'(wr_addr_q.size()), 32'(l));
        for (int w = 0; w < l && w < wr_addr_q.size(); w++) begin
            exp_w = {tx_q[4*w], tx_q[4*w+1], tx_q[4*w+2], tx_q[4*w+3]};
            check($sformatf("addr_w%0d", w), 32'(wr_addr_q[w]), 32'(w));
            check($sformatf("data_w%0d", w), wr_data_q[w], exp_w);
        end
        $display("load len=%0d gapmode=%0d writes=%0d first=%h", l, gapmode,
                 wr_addr_q.size(), (wr_data_q.size() > 0) ? wr_data_q[0] : 32'h0);
        tx_q.delete();
    endtask

    initial begin
        int e0;
        int l;
        rst = 1'b1;
        start = 1'b0;
        len = '0;
        in_data = '0;
        in_valid = 1'b0;
        repeat (3) tick();

        // Reset state
        check("rst_hold", 32'(cpu_hold), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ready", 32'(in_ready), 32'd0);
        check("rst_we", 32'(mem_we), 32'd0);
        check("rst_done_err", 32'({done, err}), 32'd0);
        check("rst_addr", 32'(mem_addr), 32'd0);
        check("rst_wdata", mem_wdata, 32'd0);
        rst = 1'b0;
        tick();
        $display("reset checked");

        // Two words back-to-back
        tx_q = '{8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77};
        run_load(2, 0, 1'b1, -1);

        // One word with in_valid toggling
        tx_q = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        run_load(1, 1, 1'b0, -1);

        // Rejected lengths
        wr_addr_q.delete();
        wr_data_q.delete();
        e0 = err_cnt;
        do_start(0);
        check("busy_len0", 32'(busy), 32'd0);
        tick();
        check("err_len0", 32'(err_cnt - e0), 32'd1);
        do_start(NUM_WORDS + 1);
        check("busy_lenmax1", 32'(busy), 32'd0);
        tick();
        tick();
        check("err_lenmax1", 32'(err_cnt - e0), 32'd2);
        check("err_no_write", 32'(wr_addr_q.size()), 32'd0);
        check("err_hold_kept", 32'(cpu_hold), 32'd0);
        $display("rejected starts len=0 and len=%0d", NUM_WORDS + 1);

        // Reset in the middle of the second word of a 3-word load
        wr_addr_q.delete();
        wr_data_q.delete();
        do_start(3);
        for (int i = 0; i < 6; i++) send_byte(8'(8'hA0 + i), 0);
        rst = 1'b1;
        #2;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_hold", 32'(cpu_hold), 32'd1);
        check("midrst_ready", 32'(in_ready), 32'd0);
        tick();
        rst = 1'b0;
        in_valid = 1'b1;
        in_data = 8'h55;
        repeat (10) tick();
        in_valid = 1'b0;
        check("midrst_writes", 32'(wr_addr_q.size()), 32'd1);
        check("midrst_hold_idle", 32'(cpu_hold), 32'd1);
        $display("reset mid-load, writes before reset=%0d", wr_addr_q.size());
        run_load(1, 0, 1'b1, -1);

        // start during RECV must be ignored
        run_load(2, 0, 1'b0, 2);

        // Largest legal program
        run_load(NUM_WORDS, 0, 1'b1, -1);

        // Randomized loads
        for (int t = 0; t < 10; t++) begin
            l = int'($urandom_range(1, 5));
            if (t % 2 == 0) run_load(l, 0, 1'b1, -1);
            else            run_load(l, 2, 1'b0, -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/inst_loader.md
INST_LOADER -- requirements
Module: inst_loader

Interface
REQ-001 Parameter ADDR_W, default 10, instruction-memory word-address width.
REQ-002 Parameter NUM_WORDS, default 1024, instruction-memory depth in 32-bit words.
REQ-003 clk  input  1  single system clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 start  input  1  one-cycle request to begin a program load.
REQ-006 len  input  ADDR_W+1  number of 32-bit words to load; sampled on accepted start.
REQ-007 in_data  input  8  program byte stream, first byte of each word is its MSB.
REQ-008 in_valid  input  1  in_data valid.
REQ-009 in_ready  output  1  loader accepts byte; a byte transfers when in_valid && in_ready.
REQ-010 mem_we  output  1  instruction-memory write strobe.
REQ-011 mem_addr  output  ADDR_W  instruction-memory word address.
REQ-012 mem_wdata  output  32  instruction word to write.
REQ-013 cpu_hold  output  1  high holds the CPU in reset while no valid program is loaded.
REQ-014 busy  output  1  high in any non-IDLE state.
REQ-015 done  output  1  one-cycle pulse on load completion.
REQ-016 err  output  1  one-cycle pulse on rejected start.

Function
REQ-017 FSM states: IDLE, RECV, WRITE, DONE; all outputs decode from registered state/datapath, no combinational input-to-output path except none.
REQ-018 IDLE: start with 1 <= len <= NUM_WORDS -> RECV next cycle, word index cleared, byte count cleared, cpu_hold set to 1.
REQ-019 IDLE: start with len == 0 or len > NUM_WORDS -> err high next cycle for exactly one cycle, remain IDLE, cpu_hold unchanged.
REQ-020 start is ignored in any state other than IDLE.
REQ-021 RECV: in_ready = 1; each transfer shifts word <= {word[23:0], in_data}, byte count increments modulo 4.
REQ-022 RECV: transfer of 4th byte -> WRITE next cycle; in_ready = 0 in WRITE, DONE, IDLE.
REQ-023 WRITE: exactly one cycle, mem_we = 1, mem_addr = word index, mem_wdata = assembled word.
REQ-024 WRITE exit: if word index == len-1 -> DONE, else word index increments, -> RECV.
REQ-025 DONE: done = 1 for one cycle, cpu_hold = 0 from the following cycle, -> IDLE.
REQ-026 Throughput: minimum 5 cycles per word (4 byte cycles + 1 write cycle); in_valid gaps stall RECV without loss.
REQ-027 mem_we = 0 in all states except WRITE; mem_addr/mem_wdata hold last values outside WRITE.
REQ-028 Word index never exceeds NUM_WORDS-1; no address wrap possible given REQ-019.

Reset
REQ-029 rst asserted: state = IDLE, cpu_hold = 1, in_ready/mem_we/busy/done/err = 0, mem_addr = 0, mem_wdata = 0, counters = 0, asynchronously.
REQ-030 rst mid-load: partial word discarded, no further mem_we, memory contents already written left as is, cpu_hold stays 1 until a subsequent load completes.

Structure
REQ-031 Shared package inst_loader_pkg holds FSM state encoding, BYTES_PER_WORD = 4, word width 32.
REQ-032 One sub-module byte_packer: 8-to-32 shift register with 2-bit byte counter and word_full flag.
REQ-033 Loader instantiated upstream of the CPU; mem_* drive the instruction-memory write port, cpu_hold ORed into the CPU reset.

Verification
REQ-034 Reset -> cpu_hold = 1, busy = 0, in_ready = 0, mem_we = 0.
REQ-035 start, len = 2, bytes 00 11 22 33 44 55 66 77 back-to-back -> writes addr0 = 0x00112233, addr1 = 0x44556677, done pulse at cycle 11 after start, cpu_hold = 0 afterwards.
REQ-036 start, len = 1, in_valid toggled every other cycle, bytes DE AD BE EF -> single write addr0 = 0xDEADBEEF, no byte lost or duplicated.
REQ-037 start with len = 0, then len = NUM_WORDS+1 -> err pulse each, busy stays 0, no mem_we.
REQ-038 rst asserted after 2 bytes of word 1 of len = 3 -> immediate IDLE, no further mem_we, cpu_hold = 1; new load of len = 1 completes normally.
REQ-039 start asserted during RECV -> ignored, len and word index unchanged, load completes with original len.
